// File: rtl/tlb_op_ctrl_if.sv
// tlb_op_pkg: TLB entry and search-result types plus op-code encodings.
// tlb_op_ctrl_if: request/response bundle between the CSR unit (master)
// and tlb_op_ctrl (slave).
package tlb_op_pkg;

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic        e;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    // index is sized for the largest supported TLB; users take the low TLBIDLEN bits
    typedef struct packed {
        logic        found;
        logic [7:0]  index;
        logic [19:0] ppn;
        logic [5:0]  ps;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_result_t;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

endpackage

interface tlb_op_ctrl_if #(
    parameter int TLBIDLEN = 4
) ();
    import tlb_op_pkg::*;

    logic                op_valid;
    logic                op_ready;
    logic [2:0]          op_code;
    logic [TLBIDLEN-1:0] csr_index;
    logic [18:0]         csr_vppn;
    logic [9:0]          csr_asid;
    tlb_entry_t          csr_entry;
    logic [4:0]          inv_op;
    logic [9:0]          inv_asid;
    logic [31:0]         inv_va;
    logic                done;
    logic [2:0]          done_op;
    logic                op_err;
    logic                res_ne;
    logic [TLBIDLEN-1:0] res_index;
    tlb_entry_t          res_entry;
    logic                refetch_req;

    modport master (
        output op_valid, op_code, csr_index, csr_vppn, csr_asid, csr_entry,
               inv_op, inv_asid, inv_va,
        input  op_ready, done, done_op, op_err, res_ne, res_index, res_entry,
               refetch_req
    );

    modport slave (
        input  op_valid, op_code, csr_index, csr_vppn, csr_asid, csr_entry,
               inv_op, inv_asid, inv_va,
        output op_ready, done, done_op, op_err, res_ne, res_index, res_entry,
               refetch_req
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB against the TLB.
// IDLE accepts and loads the TLB port registers, EXEC is the single cycle the
// TLB sees the strobe, RESP returns a one-cycle done pulse with results.
// Optional macro TLB_FILL_LFSR_EN: FILL victim index comes from a 16-bit
// Fibonacci LFSR (taps 16,14,13,11) instead of a free-running up-counter.
module tlb_op_ctrl
    import tlb_op_pkg::*;
#(
    parameter int TLBNUM   = 16,
    parameter int TLBIDLEN = 4
) (
    input  logic                clk,
    input  logic                resetn,
    tlb_op_ctrl_if.slave        op,
    output logic [18:0]         s2_vppn,
    output logic                s2_va_bit12,
    output logic [9:0]          s2_asid,
    input  tlb_result_t         s2_result,
    output logic                we,
    output logic [TLBIDLEN-1:0] w_index,
    output tlb_entry_t          w_entry,
    output logic [TLBIDLEN-1:0] r_index,
    input  tlb_entry_t          r_entry,
    output logic                invtlb_valid,
    output logic [4:0]          invtlb_op,
    output logic [9:0]          invtlb_asid,
    output logic [31:0]         invtlb_va
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r;
    logic [2:0]          code_r;
    logic                err_r;
    logic                done_r;
    logic [2:0]          done_op_r;
    logic                op_err_r;
    logic                refetch_r;
    logic                res_ne_r;
    logic [TLBIDLEN-1:0] res_index_r;
    tlb_entry_t          res_entry_r;
    logic [TLBIDLEN-1:0] fill_idx_s;
    logic                unused_s;

    // Undefined op codes, and INVTLB ops beyond 6, complete with an error and no strobe.
    function automatic logic op_illegal(input logic [2:0] code, input logic [4:0] iop);
        return (code > OP_INV) || ((code == OP_INV) && (iop > 5'd6));
    endfunction

    // Feedback bit for the x^16 + x^14 + x^13 + x^11 + 1 Fibonacci LFSR.
    function automatic logic lfsr_fb(input logic [15:0] s);
        return s[15] ^ s[13] ^ s[12] ^ s[10];
    endfunction

`ifdef TLB_FILL_LFSR_EN
    logic [15:0] lfsr_r;

    // Pseudo-random FILL victim source, stepping every cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_fb(lfsr_r)};
        end
    end

    assign fill_idx_s = lfsr_r[TLBIDLEN-1:0];
`else
    localparam logic [TLBIDLEN-1:0] LAST_IDX = TLBIDLEN'(TLBNUM - 1);
    logic [TLBIDLEN-1:0] fill_cnt_r;

    // Round-robin FILL victim source, wrapping after the last entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_cnt_r <= '0;
        end else if (fill_cnt_r == LAST_IDX) begin
            fill_cnt_r <= '0;
        end else begin
            fill_cnt_r <= fill_cnt_r + {{(TLBIDLEN-1){1'b0}}, 1'b1};
        end
    end

    assign fill_idx_s = fill_cnt_r;
`endif

    // Sequencer: accept, one strobe cycle at the TLB, then the response pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            code_r       <= 3'd0;
            err_r        <= 1'b0;
            s2_vppn      <= 19'd0;
            s2_asid      <= 10'd0;
            we           <= 1'b0;
            w_index      <= '0;
            w_entry      <= '0;
            r_index      <= '0;
            invtlb_valid <= 1'b0;
            invtlb_op    <= 5'd0;
            invtlb_asid  <= 10'd0;
            invtlb_va    <= 32'd0;
            done_r       <= 1'b0;
            done_op_r    <= 3'd0;
            op_err_r     <= 1'b0;
            refetch_r    <= 1'b0;
            res_ne_r     <= 1'b0;
            res_index_r  <= '0;
            res_entry_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (op.op_valid) begin
                        state_r <= ST_EXEC;
                        code_r  <= op.op_code;
                        err_r   <= op_illegal(op.op_code, op.inv_op);
                        case (op.op_code)
                            OP_SRCH: begin
                                s2_vppn <= op.csr_vppn;
                                s2_asid <= op.csr_asid;
                            end
                            OP_RD: begin
                                r_index <= op.csr_index;
                            end
                            OP_WR: begin
                                we      <= 1'b1;
                                w_index <= op.csr_index;
                                w_entry <= op.csr_entry;
                            end
                            OP_FILL: begin
                                we      <= 1'b1;
                                w_index <= fill_idx_s;
                                w_entry <= op.csr_entry;
                            end
                            OP_INV: begin
                                if (op.inv_op <= 5'd6) begin
                                    invtlb_valid <= 1'b1;
                                    invtlb_op    <= op.inv_op;
                                    invtlb_asid  <= op.inv_asid;
                                    invtlb_va    <= op.inv_va;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    state_r      <= ST_RESP;
                    we           <= 1'b0;
                    invtlb_valid <= 1'b0;
                    done_r       <= 1'b1;
                    done_op_r    <= code_r;
                    op_err_r     <= err_r;
                    refetch_r    <= !err_r && ((code_r == OP_WR) || (code_r == OP_FILL) ||
                                               (code_r == OP_INV));
                    case (code_r)
                        OP_SRCH: begin
                            res_ne_r    <= !s2_result.found;
                            res_index_r <= s2_result.found ? s2_result.index[TLBIDLEN-1:0] : '0;
                        end
                        OP_RD: begin
                            res_ne_r    <= !r_entry.e;
                            res_entry_r <= r_entry.e ? r_entry : '0;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_RESP: begin
                    state_r   <= ST_IDLE;
                    done_r    <= 1'b0;
                    op_err_r  <= 1'b0;
                    refetch_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign op.op_ready    = (state_r == ST_IDLE);
    assign op.done        = done_r;
    assign op.done_op     = done_op_r;
    assign op.op_err      = op_err_r;
    assign op.res_ne      = res_ne_r;
    assign op.res_index   = res_index_r;
    assign op.res_entry   = res_entry_r;
    assign op.refetch_req = refetch_r;
    assign s2_va_bit12    = 1'b0;

    // Translation fields of the search result are consumed by the CSR unit, not here.
    assign unused_s = ^s2_result;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a behavioural 16-entry TLB model.
module tb_tlb_op_ctrl;
    import tlb_op_pkg::*;

    logic        clk;
    logic        resetn;
    logic        mem_clr;
    logic [18:0] s2_vppn;
    logic        s2_va_bit12;
    logic [9:0]  s2_asid;
    tlb_result_t s2_result;
    logic        we;
    logic [3:0]  w_index;
    tlb_entry_t  w_entry;
    logic [3:0]  r_index;
    tlb_entry_t  r_entry;
    logic        invtlb_valid;
    logic [4:0]  invtlb_op;
    logic [9:0]  invtlb_asid;
    logic [31:0] invtlb_va;

    int checks   = 0;
    int failures = 0;

    tlb_entry_t mem [16];
    tlb_entry_t e9, e5, e2, e7, ef;
    logic [15:0] lf;
    logic [3:0]  exp_fill;

    tlb_op_ctrl_if #(.TLBIDLEN(4)) bus ();

    tlb_op_ctrl #(.TLBNUM(16), .TLBIDLEN(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .op           (bus.slave),
        .s2_vppn      (s2_vppn),
        .s2_va_bit12  (s2_va_bit12),
        .s2_asid      (s2_asid),
        .s2_result    (s2_result),
        .we           (we),
        .w_index      (w_index),
        .w_entry      (w_entry),
        .r_index      (r_index),
        .r_entry      (r_entry),
        .invtlb_valid (invtlb_valid),
        .invtlb_op    (invtlb_op),
        .invtlb_asid  (invtlb_asid),
        .invtlb_va    (invtlb_va)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TLB model: synchronous write, asynchronous read, lowest matching index wins
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (we) begin
            mem[w_index] <= w_entry;
        end
    end

    assign r_entry = mem[r_index];

    always_comb begin
        s2_result = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mem[i].e && (mem[i].vppn == s2_vppn) && (mem[i].g || (mem[i].asid == s2_asid))) begin
                s2_result.found = 1'b1;
                s2_result.index = 8'(i);
            end
        end
    end

    function automatic logic [15:0] lfsr_ref(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request for exactly one accept edge; returns at the EXEC negedge.
    task automatic drive_op(input logic [2:0] code, input logic [3:0] idx, input tlb_entry_t ent,
                            input logic [18:0] vppn, input logic [9:0] asid, input logic [4:0] iop);
        @(negedge clk);
        bus.op_valid  = 1'b1;
        bus.op_code   = code;
        bus.csr_index = idx;
        bus.csr_entry = ent;
        bus.csr_vppn  = vppn;
        bus.csr_asid  = asid;
        bus.inv_op    = iop;
        bus.inv_asid  = 10'h2a;
        bus.inv_va    = 32'hdead_b000;
        @(negedge clk);
        bus.op_valid  = 1'b0;
        bus.csr_index = ~idx;
        bus.csr_entry = '0;
        bus.inv_op    = 5'd0;
    endtask

    task automatic do_wr(input logic [3:0] idx, input tlb_entry_t ent);
        drive_op(OP_WR, idx, ent, 19'd0, 10'd0, 5'd0);
        check("wr_we_exec", 128'(we), 128'(1'b1));
        check("wr_index", 128'(w_index), 128'(idx));
        check("wr_entry", 128'(w_entry), 128'(ent));
        check("wr_inv_quiet", 128'(invtlb_valid), 128'(1'b0));
        @(negedge clk);
        check("wr_we_resp", 128'(we), 128'(1'b0));
        check("wr_done", 128'(bus.done), 128'(1'b1));
        check("wr_refetch", 128'(bus.refetch_req), 128'(1'b1));
        check("wr_done_op", 128'(bus.done_op), 128'(OP_WR));
    endtask

    initial begin
        bus.op_valid = 1'b0; bus.op_code = 3'd0; bus.csr_index = 4'd0; bus.csr_vppn = 19'd0;
        bus.csr_asid = 10'd0; bus.csr_entry = '0; bus.inv_op = 5'd0; bus.inv_asid = 10'd0;
        bus.inv_va = 32'd0;
        e9 = '0; e9.vppn = 19'h0abcd; e9.asid = 10'h5; e9.e = 1'b1; e9.ppn0 = 20'h11111; e9.v0 = 1'b1;
        e5 = '0; e5.vppn = 19'h1234;  e5.asid = 10'h3; e5.e = 1'b1; e5.ppn0 = 20'h55555;
        e2 = '0; e2.vppn = 19'h2222;  e2.asid = 10'h3; e2.e = 1'b1; e2.g = 1'b1; e2.ppn1 = 20'h22222;
        e2.plv1 = 2'd3;
        e7 = '0; e7.vppn = 19'h7777;  e7.asid = 10'h3; e7.e = 1'b0; e7.ppn0 = 20'h77777;
        ef = '0; ef.vppn = 19'h5f5f5; ef.e = 1'b1; ef.ps = 6'd12;

        resetn = 1'b0;
        mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(bus.op_ready), 128'(1'b1));
        check("rst_done", 128'(bus.done), 128'(1'b0));
        check("rst_we", 128'(we), 128'(1'b0));
        check("rst_inv", 128'(invtlb_valid), 128'(1'b0));
        check("rst_err", 128'(bus.op_err), 128'(1'b0));
        check("rst_ne", 128'(bus.res_ne), 128'(1'b0));
        check("rst_refetch", 128'(bus.refetch_req), 128'(1'b0));
        check("rst_windex", 128'(w_index), 128'(4'd0));
        check("rst_res_entry", 128'(bus.res_entry), 128'(0));
        check("rst_done_op", 128'(bus.done_op), 128'(3'd0));
        check("rst_s2_vppn", 128'(s2_vppn), 128'(19'd0));
        mem_clr = 1'b0;
        resetn  = 1'b1;

        do_wr(4'd9, e9);
        do_wr(4'd5, e5);
        do_wr(4'd2, e2);
        do_wr(4'd7, e7);

        drive_op(OP_SRCH, 4'd0, '0, 19'h1234, 10'h3, 5'd0);
        check("srch_vppn", 128'(s2_vppn), 128'(19'h1234));
        check("srch_asid", 128'(s2_asid), 128'(10'h3));
        check("srch_bit12", 128'(s2_va_bit12), 128'(1'b0));
        check("srch_done_early", 128'(bus.done), 128'(1'b0));
        check("srch_ready_exec", 128'(bus.op_ready), 128'(1'b0));
        @(negedge clk);
        check("srch_done", 128'(bus.done), 128'(1'b1));
        check("srch_ne", 128'(bus.res_ne), 128'(1'b0));
        check("srch_index", 128'(bus.res_index), 128'(4'd5));
        check("srch_refetch", 128'(bus.refetch_req), 128'(1'b0));

        drive_op(OP_SRCH, 4'd0, '0, 19'h7777, 10'h3, 5'd0);
        @(negedge clk);
        check("srch_miss_ne", 128'(bus.res_ne), 128'(1'b1));
        check("srch_miss_index", 128'(bus.res_index), 128'(4'd0));

        drive_op(OP_RD, 4'd2, '0, 19'd0, 10'd0, 5'd0);
        check("rd2_rindex", 128'(r_index), 128'(4'd2));
        @(negedge clk);
        check("rd2_ne", 128'(bus.res_ne), 128'(1'b0));
        check("rd2_entry", 128'(bus.res_entry), 128'(e2));
        drive_op(OP_RD, 4'd9, '0, 19'd0, 10'd0, 5'd0);
        @(negedge clk);
        check("rd9_entry", 128'(bus.res_entry), 128'(e9));
        drive_op(OP_RD, 4'd7, '0, 19'd0, 10'd0, 5'd0);
        @(negedge clk);
        check("rd7_ne", 128'(bus.res_ne), 128'(1'b1));
        check("rd7_entry", 128'(bus.res_entry), 128'(0));

        drive_op(OP_INV, 4'd0, '0, 19'd0, 10'd0, 5'd2);
        check("inv2_valid", 128'(invtlb_valid), 128'(1'b1));
        check("inv2_op", 128'(invtlb_op), 128'(5'd2));
        check("inv2_asid", 128'(invtlb_asid), 128'(10'h2a));
        check("inv2_va", 128'(invtlb_va), 128'(32'hdead_b000));
        check("inv2_no_we", 128'(we), 128'(1'b0));
        @(negedge clk);
        check("inv2_valid_off", 128'(invtlb_valid), 128'(1'b0));
        check("inv2_refetch", 128'(bus.refetch_req), 128'(1'b1));
        check("inv2_err", 128'(bus.op_err), 128'(1'b0));

        drive_op(OP_INV, 4'd0, '0, 19'd0, 10'd0, 5'd9);
        check("inv9_no_strobe", 128'(invtlb_valid), 128'(1'b0));
        check("inv9_no_we", 128'(we), 128'(1'b0));
        @(negedge clk);
        check("inv9_done", 128'(bus.done), 128'(1'b1));
        check("inv9_err", 128'(bus.op_err), 128'(1'b1));
        check("inv9_refetch", 128'(bus.refetch_req), 128'(1'b0));
        check("inv9_res_hold", 128'(bus.res_ne), 128'(1'b1));

        drive_op(3'd6, 4'd0, '0, 19'd0, 10'd0, 5'd0);
        check("ill_no_we", 128'(we), 128'(1'b0));
        @(negedge clk);
        check("ill_err", 128'(bus.op_err), 128'(1'b1));
        check("ill_done_op", 128'(bus.done_op), 128'(3'd6));
        check("ill_refetch", 128'(bus.refetch_req), 128'(1'b0));

        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = OP_SRCH; bus.csr_vppn = 19'h1234; bus.csr_asid = 10'h3;
        for (int k = 0; k < 9; k++) begin
            check("b2b_ready", 128'(bus.op_ready), 128'((k % 3) == 0));
            check("b2b_done", 128'(bus.done), 128'((k % 3) == 2));
            @(negedge clk);
        end
        bus.op_valid = 1'b0;

        drive_op(OP_WR, 4'd3, e9, 19'd0, 10'd0, 5'd0);
        check("rstwr_we_before", 128'(we), 128'(1'b1));
        #2 resetn = 1'b0;
        #1;
        check("rstwr_we_async", 128'(we), 128'(1'b0));
        check("rstwr_idle", 128'(bus.op_ready), 128'(1'b1));
        check("rstwr_windex", 128'(w_index), 128'(4'd0));
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rstwr_no_done", 128'(bus.done), 128'(1'b0));
        bus.op_valid = 1'b1; bus.op_code = OP_FILL; bus.csr_entry = ef; bus.csr_index = 4'd9;
        @(negedge clk);
        bus.op_valid = 1'b0;
`ifdef TLB_FILL_LFSR_EN
        lf = lfsr_ref(20);
        exp_fill = lf[3:0];
`else
        lf = 16'd0;
        exp_fill = 4'd4;
`endif
        check("fill_we", 128'(we), 128'(1'b1));
        check("fill_index", 128'(w_index), 128'(exp_fill));
        check("fill_entry", 128'(w_entry), 128'(ef));
        @(negedge clk);
        check("fill_done", 128'(bus.done), 128'(1'b1));
        check("fill_refetch", 128'(bus.refetch_req), 128'(1'b1));
        check("fill_done_op", 128'(bus.done_op), 128'(OP_FILL));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for the TLB maintenance instructions: TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It sits between the commit-stage CSR unit and the `tlb` block. It accepts one operation at a time, drives the TLB write, read, invalidate and search-port-2 interfaces, and registers the results. It returns a single-cycle completion pulse carrying CSR update data and a refetch request.

## Interface
Parameters:
- `TLBNUM`, default 16: number of TLB entries, a power of two.
- `TLBIDLEN`, default 4: log2(`TLBNUM`).

Ports:
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, asynchronous and active-low.
- `op_valid`, in, 1: an operation request is present.
- `op_ready`, out, 1: controller can accept; high only in IDLE.
- `op_code`, in, 3: 0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; values 5–7 are illegal.
- `csr_index`, in, TLBIDLEN: TLBIDX.Index, used by RD and WR.
- `csr_vppn`, in, 19: TLBEHI.VPPN, used by SRCH.
- `csr_asid`, in, 10: ASID.ASID, used by SRCH.
- `csr_entry`, in, tlb_entry_t: entry assembled from the CSRs for WR and FILL.
- `inv_op`, in, 5: INVTLB op field.
- `inv_asid`, in, 10: INVTLB ASID operand.
- `inv_va`, in, 32: INVTLB VA operand.
- `s2_vppn`, out, 19: TLB search port 2 VPPN.
- `s2_va_bit12`, out, 1: TLB search port 2 VA bit 12.
- `s2_asid`, out, 10: TLB search port 2 ASID.
- `s2_result`, in, tlb_result_t: TLB search port 2 result.
- `we`, out, 1: TLB write enable.
- `w_index`, out, TLBIDLEN: TLB write index.
- `w_entry`, out, tlb_entry_t: TLB write data.
- `r_index`, out, TLBIDLEN: TLB read index.
- `r_entry`, in, tlb_entry_t: TLB read data.
- `invtlb_valid`, out, 1: TLB invalidate strobe.
- `invtlb_op`, out, 5: TLB invalidate op.
- `invtlb_asid`, out, 10: TLB invalidate ASID.
- `invtlb_va`, out, 32: TLB invalidate VA.
- `done`, out, 1: one-cycle completion pulse.
- `done_op`, out, 3: op code of the completing operation.
- `op_err`, out, 1: illegal `op_code` or `inv_op` > 6; qualified by `done`.
- `res_ne`, out, 1: NE result for SRCH and RD.
- `res_index`, out, TLBIDLEN: SRCH hit index.
- `res_entry`, out, tlb_entry_t: RD data.
- `refetch_req`, out, 1: asserted with `done` for a successful WR, FILL or INV.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE → EXEC on `op_valid && op_ready`. Capture `op_code`, `csr_*` and `inv_*` into holding registers. Later changes on these inputs are ignored.
- EXEC lasts exactly one cycle and always goes to RESP. Actions by op:
  - SRCH: drive `s2_vppn` = captured VPPN, `s2_va_bit12` = 0, `s2_asid` = captured ASID. Register `s2_result` at the end of the cycle. `res_ne` = !found; `res_index` = found ? index : 0.
  - RD: drive `r_index` = captured index and register `r_entry`. If `r_entry.e` = 0, then `res_ne` = 1 and `res_entry` = all zeros. Otherwise `res_ne` = 0 and `res_entry` = `r_entry`.
  - WR: assert `we` for this cycle only, with `w_index` = captured index and `w_entry` = captured entry.
  - FILL: as WR, but `w_index` = `fill_idx` sampled when the request is accepted.
  - INV with `inv_op` ≤ 6: assert `invtlb_valid` for this cycle only, driving the captured op, ASID and VA.
  - INV with `inv_op` > 6, or `op_code` 5–7: no TLB strobe; set `op_err` = 1.
- RESP: `done` = 1 for one cycle with result registers valid. `refetch_req` = (WR|FILL|INV) && !`op_err`. Return to IDLE.
- `fill_idx` is a free-running counter that increments every cycle and wraps from TLBNUM-1 to 0. It is replaced by an LFSR under the macro described in Configuration.
- `we` and `invtlb_valid` are never both high. TLB ports are driven only in EXEC; otherwise all strobes are 0 and addresses hold.
- There is no cancel: an accepted operation always completes.

## Timing
- Latency: request accepted in cycle N; TLB strobe in N+1; `done` in N+2. Next accept no earlier than N+3. Throughput is one op per 3 cycles.
- `op_ready` = (state == IDLE), combinational from the state.
- Reset values: `op_ready` = 1; `done`, `we`, `invtlb_valid`, `op_err`, `res_ne`, `refetch_req` = 0; all index, address and entry outputs = 0; `done_op` = 0.
- Asserting `resetn` low in EXEC or RESP returns to IDLE immediately and deasserts all strobes asynchronously. A write that was mid-cycle is not guaranteed to land.
- `res_*` hold their values until the next SRCH or RD completes.

## Configuration
- `TLB_FILL_LFSR_EN` defined:
  - `fill_idx` = low TLBIDLEN bits of a 16-bit Fibonacci LFSR with taps 16,14,13,11, reset to 16'hACE1, stepping every cycle.
- `TLB_FILL_LFSR_EN` undefined:
  - `fill_idx` is a TLBIDLEN-bit up-counter, reset to 0.

## Test plan
- SRCH, hit case: preload entry 5 with VPPN 19'h1234, ASID 10'h3, and a matching request. Required: `done` at accept+2, `res_ne` = 0, `res_index` = 5.
- RD of entry 7 with e = 0, then RD of entry 2 with e = 1:
  - entry 7 → `res_ne` = 1, `res_entry` = 0;
  - entry 2 → `res_ne` = 0 and `res_entry` equal to the written entry.
- WR with `csr_index` = 9: `we` high for exactly one cycle, `w_index` = 9, `refetch_req` = 1 with `done`. A subsequent RD of 9 returns the written data.
- FILL, counter build: reset, then accept a FILL exactly 20 cycles after `resetn` rises. Required: `w_index` = 20 mod 16 = 4. Repeat the test with `TLB_FILL_LFSR_EN` and compare against the reference LFSR sequence.
- INV:
  - `inv_op` = 2 → `invtlb_valid` pulse carrying op 2;
  - `inv_op` = 9 → no strobe, `op_err` = 1, `refetch_req` = 0.
- Back-to-back and reset:
  - Hold `op_valid` high. Required: `op_ready` low in EXEC and RESP, with accepts every 3 cycles.
  - Drop `resetn` during EXEC of a WR. Required: `we` goes to 0 immediately and the state returns to IDLE.
